// File: rtl/iob_axistream_out_arb_pkg.sv
// rtl/iob_axistream_out_arb_pkg.sv - shared state encoding and pointer sizing for the stream arbiter
package iob_axistream_out_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Pointer width for n sources; a single source still needs one bit to index with.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_axistream_out_arb_rr.sv
// rtl/iob_axistream_out_arb_rr.sv - combinational round-robin pick: first requester at or after ptr, wrapping
module iob_axistream_out_arb_rr
  import iob_axistream_out_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int PTR_W = ptr_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] win,
  output logic [PTR_W-1:0] win_idx
);

  int               idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      // Explicit wrap at N_SRC so non-power-of-two source counts rotate correctly.
      idx = int'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      cand = idx[PTR_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_out_arb.sv
// rtl/iob_axistream_out_arb.sv - packet-aware round-robin arbiter onto one registered AXI-Stream output
module iob_axistream_out_arb
  import iob_axistream_out_arb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TDATA_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC*TDATA_W-1:0]   s_tdata,
  input  logic [N_SRC-1:0]           s_tvalid,
  output logic [N_SRC-1:0]           s_tready,
  input  logic [N_SRC-1:0]           s_tlast,
  output logic [TDATA_W-1:0]         m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [N_SRC-1:0]           grant,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int PTR_W = ptr_w(N_SRC);

  arb_state_e         state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   own_q, own_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [TDATA_W-1:0] m_tdata_q, m_tdata_d;
  logic               m_tlast_q, m_tlast_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [N_SRC-1:0]   win;
  logic [PTR_W-1:0]   win_idx;
  logic [TDATA_W-1:0] src_data [N_SRC];
  logic               load_ok;
  logic               beat;

  for (genvar i = 0; i < N_SRC; i++) begin : g_split
    assign src_data[i] = s_tdata[i*TDATA_W +: TDATA_W];
  end

  iob_axistream_out_arb_rr #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (s_tvalid),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // The output stage can take a beat when empty or being drained this cycle.
  assign load_ok  = ~m_tvalid_q | m_tready;
  assign s_tready = (state_q == ARB_LOCK && load_ok) ? grant_q : '0;
  assign beat     = (state_q == ARB_LOCK) && load_ok && s_tvalid[own_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|s_tvalid) begin
          state_d = ARB_LOCK;
          grant_d = win;
          own_d   = win_idx;
          ptr_d   = (win_idx == PTR_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ARB_LOCK: begin
        if (beat && s_tlast[own_q]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (beat) begin
      m_tdata_d  = src_data[own_q];
      m_tlast_d  = s_tlast[own_q];
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
    if (m_tvalid_q && m_tready && m_tlast_q) pkt_cnt_d = pkt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      ptr_q      <= '0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      own_q      <= own_d;
      ptr_q      <= ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign grant    = grant_q;
  assign busy     = (state_q == ARB_LOCK) | m_tvalid_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// tb/tb_iob_axistream_out_arb.sv - directed and randomized checks of the packet round-robin arbiter
module tb_iob_axistream_out_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tready, s_tlast, grant;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, busy;
  logic [3:0]  pkt_cnt;

  always #5 clk = ~clk;

  iob_axistream_out_arb #(.N_SRC(4), .TDATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Producer queues (popped on acceptance) and expected-output queues (popped on delivery).
  logic [7:0] q_d [4][$];
  bit         q_l [4][$];
  logic [7:0] e_d [4][$];
  bit         e_l [4][$];
  int         e_pkts [4];
  bit         started [4];
  int         pause_cnt [4];
  int         mptr, model_cnt, cyc, first_acc, last_acc, seq;
  bit         out_sop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0; model_cnt = 0; out_sop = 1'b1;
    for (int i = 0; i < 4; i++) begin started[i] = 1'b0; pause_cnt[i] = 0; e_pkts[i] = 0; end
  endtask

  task automatic add_pkt(input int src, input int len);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = {src[1:0], seq[5:0]};
      seq++;
      q_d[src].push_back(d); q_l[src].push_back(b == len - 1);
      e_d[src].push_back(d); e_l[src].push_back(b == len - 1);
    end
    e_pkts[src]++;
  endtask

  // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1
  task automatic run_traffic(input int mode, input bit rnd_pause, input int force_src,
                             input int force_len, input int max_cyc);
    bit         paused [4];
    bit         prev_stall, done, was_start;
    logic [7:0] prev_d;
    bit         prev_l;
    int         exp_src, cur_src, s;
    prev_stall = 0; done = 0; cur_src = 0; first_acc = -1; last_acc = -1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        paused[i] = 0; s_tvalid[i] = 0; s_tlast[i] = 0; s_tdata[i*8 +: 8] = 8'h00;
        if (q_d[i].size() > 0) begin
          if (started[i] && pause_cnt[i] > 0) begin paused[i] = 1; pause_cnt[i]--; end
          else if (started[i] && rnd_pause && $urandom_range(0, 3) == 0) paused[i] = 1;
          if (!paused[i]) begin
            s_tvalid[i] = 1; s_tdata[i*8 +: 8] = q_d[i][0]; s_tlast[i] = q_l[i][0];
          end
        end
      end
      m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1))
               : ((c % 4 == 0) || (c % 4 == 3));
      #1;
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("s_tready", s_tready, grant & {4{~m_tvalid | m_tready}});
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", m_tlast, prev_l);
      end
      for (int i = 0; i < 4; i++) if (paused[i]) chk("pause_grant", grant[i], 1);
      if (m_tvalid && m_tready) begin
        if (out_sop) begin
          exp_src = -1;
          for (int k = 0; k < 4; k++) begin
            s = (mptr + k) % 4;
            if (exp_src < 0 && e_pkts[s] > 0) exp_src = s;
          end
          chk("pkt_src", m_tdata[7:6], exp_src);
          if (exp_src >= 0) begin cur_src = exp_src; mptr = (exp_src + 1) % 4; e_pkts[exp_src]--; end
        end
        chk("beat_avail", 32'(e_d[cur_src].size() > 0), 1);
        if (e_d[cur_src].size() > 0) begin
          chk("out_data", m_tdata, e_d[cur_src][0]);
          chk("out_last", m_tlast, e_l[cur_src][0]);
          void'(e_d[cur_src].pop_front()); void'(e_l[cur_src].pop_front());
        end
        out_sop = m_tlast;
        if (m_tlast) model_cnt++;
      end
      for (int i = 0; i < 4; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          was_start = !started[i];
          started[i] = !q_l[i][0];
          void'(q_d[i].pop_front()); void'(q_l[i].pop_front());
          if (was_start && started[i] && i == force_src) pause_cnt[i] = force_len;
        end
      end
      prev_stall = m_tvalid & ~m_tready; prev_d = m_tdata; prev_l = m_tlast;
      cyc++;
      done = 1;
      for (int i = 0; i < 4; i++) if (q_d[i].size() != 0 || e_d[i].size() != 0) done = 0;
    end
    chk("traffic_done", 32'(done), 1);
    @(negedge clk);
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    #1;
    chk("pkt_cnt_model", pkt_cnt, model_cnt % 16);
  endtask

  initial begin
    cyc = 0; seq = 0;
    reset_dut();
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);

    // Single source: src1 sends 0x11, 0x12, 0x13
    s_tvalid = 4'b0010; s_tdata[15:8] = 8'h11; s_tlast = 4'b0000; m_tready = 1'b1;
    #1;
    chk("ss_idle_grant", grant, 0);
    chk("ss_idle_ready", s_tready, 0);
    @(negedge clk); #1;
    chk("ss_grant", grant, 4'b0010);
    chk("ss_ready", s_tready, 4'b0010);
    @(negedge clk); #1;
    chk("ss_d0", m_tdata, 8'h11); chk("ss_v0", m_tvalid, 1); chk("ss_l0", m_tlast, 0);
    s_tdata[15:8] = 8'h12;
    @(negedge clk); #1;
    chk("ss_d1", m_tdata, 8'h12); chk("ss_l1", m_tlast, 0);
    s_tdata[15:8] = 8'h13; s_tlast = 4'b0010;
    @(negedge clk); #1;
    chk("ss_d2", m_tdata, 8'h13); chk("ss_l2", m_tlast, 1);
    chk("ss_released", grant, 0); chk("ss_cnt_before", pkt_cnt, 0);
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    @(negedge clk); #1;
    chk("ss_cnt", pkt_cnt, 1); chk("ss_empty", m_tvalid, 0); chk("ss_busy", busy, 0);

    // Reset mid-packet: src2 beat 2 of 4 stalled, ptr was left at 2
    s_tvalid = 4'b0100; s_tdata[23:16] = 8'hA1; m_tready = 1'b0;
    @(negedge clk); #1;
    chk("rm_grant", grant, 4'b0100);
    @(negedge clk); #1;
    chk("rm_full", m_tvalid, 1); chk("rm_stall_ready", s_tready, 0);
    s_tdata[23:16] = 8'hA2; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_valid", m_tvalid, 0); chk("rm_grant0", grant, 0); chk("rm_cnt", pkt_cnt, 0);
    s_tvalid = 4'b1100; s_tdata[23:16] = 8'hB1; s_tdata[31:24] = 8'hC1; s_tlast = 4'b1100;
    m_tready = 1'b1;
    @(negedge clk); #1;
    chk("rm_ptr0_grant", grant, 4'b0100);
    s_tvalid = '0;

    // Round-robin order with 2-beat packets, one dead input cycle per packet
    reset_dut();
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2); add_pkt(3, 2); add_pkt(0, 2);
    run_traffic(0, 0, -1, 0, 200);
    chk("rr_span", last_acc - first_acc, 13);
    chk("rr_cnt", pkt_cnt, 5);

    // Backpressure on src2
    reset_dut();
    add_pkt(2, 4);
    run_traffic(2, 0, -1, 0, 200);

    // Owner pause: src0 idles 5 cycles mid-packet while src3 waits
    reset_dut();
    add_pkt(0, 3); add_pkt(3, 1);
    run_traffic(0, 0, 0, 5, 200);

    // Counter wrap at CNT_W=4
    reset_dut();
    for (int p = 0; p < 17; p++) add_pkt($urandom_range(0, 3), 1);
    run_traffic(1, 0, -1, 0, 2000);
    chk("cnt_wrap", pkt_cnt, 1);

    // Randomized traffic
    reset_dut();
    for (int p = 0; p < 24; p++) add_pkt($urandom_range(0, 3), $urandom_range(1, 4));
    run_traffic(1, 1, -1, 0, 5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
